// File: rtl/datapath_pkg.sv
// Shared types for the sequenced single-bus datapath: opcodes, sequencer states
// and bus source selects.
package datapath_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SHL  = 4'd4,
        OP_SHR  = 4'd5,
        OP_SHRA = 4'd6,
        OP_MUL  = 4'd7,
        OP_NOT  = 4'd8,
        OP_NEG  = 4'd9
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        BUS_GPR  = 2'd0,
        BUS_ZLO  = 2'd1,
        BUS_ZHI  = 2'd2,
        BUS_ZERO = 2'd3
    } bus_sel_t;

    localparam logic [3:0] OP_LAST_LEGAL = 4'd9;

    function automatic logic op_legal(input logic [3:0] code);
        return (code <= OP_LAST_LEGAL);
    endfunction

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: Y operand (A) and bus operand (B) to a 2W-bit Z value.
// Only MUL produces a non-zero upper half.
module datapath_alu
    import datapath_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    input  logic [3:0]     i_op,
    output logic [2*W-1:0] o_z
);

    localparam int SW = $clog2(W);

    logic [SW-1:0]  w_sh;
    logic [2*W-1:0] w_a_ext;
    logic [2*W-1:0] w_b_ext;
    logic [2*W-1:0] w_prod;
    logic [W-1:0]   w_lo;

    // Only the low bits of B form the shift distance; the rest are ignored.
    assign w_sh = i_b[SW-1:0];

    // Low 2W bits of the product of sign-extended operands equal the signed product.
    assign w_a_ext = {{W{i_a[W-1]}}, i_a};
    assign w_b_ext = {{W{i_b[W-1]}}, i_b};
    assign w_prod  = w_a_ext * w_b_ext;

    always_comb begin
        w_lo = '0;
        case (i_op)
            OP_ADD:  w_lo = i_a + i_b;
            OP_SUB:  w_lo = i_a - i_b;
            OP_AND:  w_lo = i_a & i_b;
            OP_OR:   w_lo = i_a | i_b;
            OP_SHL:  w_lo = i_a << w_sh;
            OP_SHR:  w_lo = i_a >> w_sh;
            OP_SHRA: w_lo = $signed(i_a) >>> w_sh;
            OP_NOT:  w_lo = ~i_a;
            OP_NEG:  w_lo = -i_a;
            default: w_lo = '0;
        endcase
    end

    assign o_z = (i_op == OP_MUL) ? w_prod : {{W{1'b0}}, w_lo};

endmodule

// File: rtl/seq_datapath.sv
// Single-bus datapath with a built-in micro-sequencer that runs one
// register-register instruction (ra <= rb op rc) per start/done handshake.
module seq_datapath
    import datapath_pkg::*;
#(
    parameter int W       = 32,
    parameter int NREGS   = 16,
    parameter bit R0_ZERO = 1'b0,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          start,
    input  logic [3:0]    op,
    input  logic [AW-1:0] ra,
    input  logic [AW-1:0] rb,
    input  logic [AW-1:0] rc,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data,
    output logic [W-1:0]  hi,
    output logic [W-1:0]  lo,
    output logic [W-1:0]  bus,
    output logic          busy,
    output logic          done,
    output logic          err,
    output state_t        dbg_state
);

    // Handshake: start is taken on any edge where busy=0 (IDLE or DONE), sampling
    // op/ra/rb/rc with it; done pulses for the single DONE cycle; start while busy
    // is ignored, and holding start through DONE chains the next instruction.

    state_t         r_state;
    state_t         w_next;

    logic [3:0]     r_op;
    logic [AW-1:0]  r_ra;
    logic [AW-1:0]  r_rb;
    logic [AW-1:0]  r_rc;
    logic           r_illegal;
    logic           r_wr_rej;

    logic [W-1:0]   r_regs [NREGS];
    logic [W-1:0]   r_y;
    logic [2*W-1:0] r_z;
    logic [W-1:0]   r_hi;
    logic [W-1:0]   r_lo;

    logic           w_accept;
    logic           w_y_ld;
    logic           w_z_ld;
    logic           w_lo_ld;
    logic           w_hi_ld;
    logic           w_gpr_wr;
    bus_sel_t       w_bus_sel;
    logic [AW-1:0]  w_rd_sel;
    logic [W-1:0]   w_gpr_rd;
    logic [W-1:0]   w_bus;
    logic [2*W-1:0] w_alu_z;
    logic           w_busy;
    logic           w_host_wr;
    logic           w_seq_wr;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_y_ld    = 1'b0;
        w_z_ld    = 1'b0;
        w_lo_ld   = 1'b0;
        w_hi_ld   = 1'b0;
        w_gpr_wr  = 1'b0;
        w_bus_sel = BUS_ZERO;
        w_rd_sel  = r_rb;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = op_legal(op) ? ST_T1 : ST_DONE;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_T1: begin
                w_bus_sel = BUS_GPR;
                w_rd_sel  = r_rb;
                w_y_ld    = 1'b1;
                w_next    = ST_T2;
            end
            ST_T2: begin
                // Unary ops see a zero B operand so the ALU works on Y alone.
                w_bus_sel = (r_op == OP_NOT || r_op == OP_NEG) ? BUS_ZERO : BUS_GPR;
                w_rd_sel  = r_rc;
                w_z_ld    = 1'b1;
                w_next    = ST_T3;
            end
            ST_T3: begin
                w_bus_sel = BUS_ZLO;
                if (r_op == OP_MUL) begin
                    w_lo_ld = 1'b1;
                    w_next  = ST_T4;
                end else begin
                    w_gpr_wr = 1'b1;
                    w_next   = ST_DONE;
                end
            end
            ST_T4: begin
                w_bus_sel = BUS_ZHI;
                w_hi_ld   = 1'b1;
                w_next    = ST_DONE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_busy = (r_state == ST_T1) || (r_state == ST_T2) ||
                    (r_state == ST_T3) || (r_state == ST_T4);

    assign w_gpr_rd = (R0_ZERO && (w_rd_sel == '0)) ? '0 : r_regs[w_rd_sel];

    always_comb begin
        w_bus = '0;
        case (w_bus_sel)
            BUS_GPR:  w_bus = w_gpr_rd;
            BUS_ZLO:  w_bus = r_z[W-1:0];
            BUS_ZHI:  w_bus = r_z[2*W-1:W];
            default:  w_bus = '0;
        endcase
    end

    datapath_alu #(
        .W (W)
    ) u_alu (
        .i_a  (r_y),
        .i_b  (w_bus),
        .i_op (r_op),
        .o_z  (w_alu_z)
    );

    // Host writes only land while idle; the sequence writes only in T3, so the
    // two write ports never collide.
    assign w_host_wr = wr_en && !w_busy && !(R0_ZERO && (wr_addr == '0));
    assign w_seq_wr  = w_gpr_wr && !(R0_ZERO && (r_ra == '0));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_host_wr) begin
                r_regs[wr_addr] <= wr_data;
            end
            if (w_seq_wr) begin
                r_regs[r_ra] <= w_bus;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_op      <= '0;
            r_ra      <= '0;
            r_rb      <= '0;
            r_rc      <= '0;
            r_illegal <= 1'b0;
            r_wr_rej  <= 1'b0;
            r_y       <= '0;
            r_z       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            if (w_accept) begin
                r_op      <= op;
                r_ra      <= ra;
                r_rb      <= rb;
                r_rc      <= rc;
                r_illegal <= !op_legal(op);
            end
            r_wr_rej <= wr_en && w_busy;
            if (w_y_ld) begin
                r_y <= w_bus;
            end
            if (w_z_ld) begin
                r_z <= w_alu_z;
            end
            if (w_lo_ld) begin
                r_lo <= w_bus;
            end
            if (w_hi_ld) begin
                r_hi <= w_bus;
            end
        end
    end

    assign rd_data   = (R0_ZERO && (rd_addr == '0)) ? '0 : r_regs[rd_addr];
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign bus       = w_bus;
    assign busy      = w_busy;
    assign done      = (r_state == ST_DONE);
    assign err       = ((r_state == ST_DONE) && r_illegal) || r_wr_rej;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_datapath.sv
// Directed bench for seq_datapath: one instance with R0 as a normal register and
// one with R0 hardwired to zero, both driven by the same stimulus.
module tb_seq_datapath;
    import datapath_pkg::*;

    localparam int W  = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    op = 4'd0;
    logic [AW-1:0] ra = '0;
    logic [AW-1:0] rb = '0;
    logic [AW-1:0] rc = '0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [W-1:0]  wr_data = '0;
    logic [AW-1:0] rd_addr = '0;

    logic [W-1:0]  rd_data_a, hi_a, lo_a, bus_a;
    logic          busy_a, done_a, err_a;
    state_t        dbg_a;
    logic [W-1:0]  rd_data_b, hi_b, lo_b, bus_b;
    logic          busy_b, done_b, err_b;
    state_t        dbg_b;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    seq_datapath #(.W(W), .NREGS(16), .R0_ZERO(1'b0)) dut_a (
        .clk(clk), .clr(clr), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
        .rd_data(rd_data_a), .hi(hi_a), .lo(lo_a), .bus(bus_a), .busy(busy_a),
        .done(done_a), .err(err_a), .dbg_state(dbg_a)
    );

    seq_datapath #(.W(W), .NREGS(16), .R0_ZERO(1'b1)) dut_b (
        .clk(clk), .clr(clr), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
        .rd_data(rd_data_b), .hi(hi_b), .lo(lo_b), .bus(bus_b), .busy(busy_b),
        .done(done_b), .err(err_b), .dbg_state(dbg_b)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic rd_chk2(input string tag, input logic [AW-1:0] a,
                           input logic [W-1:0] exp_a, input logic [W-1:0] exp_b);
        rd_addr = a;
        #1;
        chk({tag, "_a"}, rd_data_a, exp_a);
        chk({tag, "_b"}, rd_data_b, exp_b);
    endtask

    task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [W-1:0] exp);
        rd_chk2(tag, a, exp, exp);
    endtask

    task automatic drive_start(input logic [3:0] o, input logic [AW-1:0] d,
                               input logic [AW-1:0] s1, input logic [AW-1:0] s2);
        start = 1'b1;
        op    = o;
        ra    = d;
        rb    = s1;
        rc    = s2;
    endtask

    // Non-MUL instruction: accept edge, three sequence edges, done for one cycle.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [AW-1:0] d,
                          input logic [AW-1:0] s1, input logic [AW-1:0] s2);
        drive_start(o, d, s1, s2);
        tick();
        start = 1'b0;
        chk1({tag, "_busy_t1"}, busy_a, 1'b1);
        tick();
        tick();
        chk1({tag, "_done_t3"}, done_a, 1'b0);
        tick();
        chk1({tag, "_done"}, done_a, 1'b1);
        chk1({tag, "_busy_done"}, busy_a, 1'b0);
        tick();
        chk1({tag, "_done_off"}, done_a, 1'b0);
    endtask

    initial begin
        // Reset
        tick();
        tick();
        chk1("rst_busy", busy_a, 1'b0);
        chk1("rst_done", done_a, 1'b0);
        chk1("rst_err", err_a, 1'b0);
        chk("rst_bus", bus_a, 32'h0);
        chk("rst_hi", hi_a, 32'h0);
        chk("rst_lo", lo_a, 32'h0);
        chk("rst_state", {29'd0, dbg_a}, {29'd0, ST_IDLE});
        clr = 1'b0;
        tick();
        rd_chk("rst_r1", 4'd1, 32'h0);

        // ADD R1 = 5 + 7, step by step
        host_write(4'd2, 32'd5);
        host_write(4'd3, 32'd7);
        drive_start(OP_ADD, 4'd1, 4'd2, 4'd3);
        tick();
        start = 1'b0;
        chk1("add_busy_e0", busy_a, 1'b1);
        chk("add_bus_t1", bus_a, 32'd5);
        tick();
        chk1("add_busy_e1", busy_a, 1'b1);
        chk("add_bus_t2", bus_a, 32'd7);
        tick();
        chk1("add_busy_e2", busy_a, 1'b1);
        chk("add_bus_t3", bus_a, 32'd12);
        rd_chk("add_r1_before", 4'd1, 32'h0);
        tick();
        chk1("add_done_e3", done_a, 1'b1);
        chk1("add_busy_e3", busy_a, 1'b0);
        chk1("add_err_e3", err_a, 1'b0);
        chk("add_bus_done", bus_a, 32'h0);
        rd_chk("add_r1", 4'd1, 32'd12);
        tick();
        chk1("add_done_e4", done_a, 1'b0);

        // SUB wraps modulo 2^W
        host_write(4'd2, 32'd0);
        host_write(4'd3, 32'd1);
        run_op("sub", OP_SUB, 4'd1, 4'd2, 4'd3);
        rd_chk("sub_r1", 4'd1, 32'hFFFF_FFFF);

        // SHRA: shift distance uses only the low 5 bits of rc
        host_write(4'd6, 32'h8000_0000);
        host_write(4'd7, 32'd4);
        run_op("shra4", OP_SHRA, 4'd8, 4'd6, 4'd7);
        rd_chk("shra4_r8", 4'd8, 32'hF800_0000);
        host_write(4'd8, 32'h0);
        host_write(4'd7, 32'd36);
        run_op("shra36", OP_SHRA, 4'd8, 4'd6, 4'd7);
        rd_chk("shra36_r8", 4'd8, 32'hF800_0000);

        // Logic, shifts and unary ops
        host_write(4'd2, 32'hF0F0_1234);
        host_write(4'd3, 32'h0FF0_00FF);
        run_op("and", OP_AND, 4'd10, 4'd2, 4'd3);
        rd_chk("and_r10", 4'd10, 32'h00F0_0034);
        run_op("or", OP_OR, 4'd11, 4'd2, 4'd3);
        rd_chk("or_r11", 4'd11, 32'hFFF0_12FF);
        run_op("shl", OP_SHL, 4'd12, 4'd2, 4'd7);
        rd_chk("shl_r12", 4'd12, 32'h0F01_2340);
        run_op("shr", OP_SHR, 4'd13, 4'd2, 4'd7);
        rd_chk("shr_r13", 4'd13, 32'h0F0F_0123);
        run_op("not", OP_NOT, 4'd14, 4'd2, 4'd3);
        rd_chk("not_r14", 4'd14, 32'h0F0F_EDCB);
        run_op("neg", OP_NEG, 4'd15, 4'd3, 4'd2);
        rd_chk("neg_r15", 4'd15, 32'hF00F_FF01);

        // MUL -3 * 6 = -18 into HI:LO
        host_write(4'd4, 32'hFFFF_FFFD);
        host_write(4'd5, 32'd6);
        drive_start(OP_MUL, 4'd9, 4'd4, 4'd5);
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("mul_bus_t3", bus_a, 32'hFFFF_FFEE);
        tick();
        chk("mul_lo_e3", lo_a, 32'hFFFF_FFEE);
        chk("mul_hi_e3", hi_a, 32'h0);
        chk1("mul_busy_e3", busy_a, 1'b1);
        chk1("mul_done_e3", done_a, 1'b0);
        chk("mul_state_e3", {29'd0, dbg_a}, {29'd0, ST_T4});
        chk("mul_bus_t4", bus_a, 32'hFFFF_FFFF);
        tick();
        chk("mul_hi_e4", hi_a, 32'hFFFF_FFFF);
        chk1("mul_done_e4", done_a, 1'b1);
        chk1("mul_busy_e4", busy_a, 1'b0);
        rd_chk("mul_r9", 4'd9, 32'h0);
        rd_chk("mul_r4", 4'd4, 32'hFFFF_FFFD);
        tick();

        // Illegal op: done+err right after the start edge, nothing changes
        drive_start(4'd12, 4'd1, 4'd2, 4'd3);
        tick();
        start = 1'b0;
        chk1("ill_done", done_a, 1'b1);
        chk1("ill_err", err_a, 1'b1);
        chk1("ill_busy", busy_a, 1'b0);
        chk("ill_hi", hi_a, 32'hFFFF_FFFF);
        chk("ill_lo", lo_a, 32'hFFFF_FFEE);
        rd_chk("ill_r1", 4'd1, 32'hFFFF_FFFF);
        tick();
        chk1("ill_done_off", done_a, 1'b0);
        chk1("ill_err_off", err_a, 1'b0);

        // Host write and start while busy: write dropped with err, start ignored
        drive_start(OP_ADD, 4'd1, 4'd2, 4'd3);
        tick();
        drive_start(4'd12, 4'd5, 4'd5, 4'd5);
        wr_en   = 1'b1;
        wr_addr = 4'd9;
        wr_data = 32'h0000_DEAD;
        tick();
        wr_en = 1'b0;
        start = 1'b0;
        chk1("drop_err", err_a, 1'b1);
        chk1("drop_busy", busy_a, 1'b1);
        tick();
        chk1("drop_err_off", err_a, 1'b0);
        tick();
        chk1("drop_done", done_a, 1'b1);
        chk1("drop_done_err", err_a, 1'b0);
        rd_chk("drop_r1", 4'd1, 32'h00E0_1333);
        rd_chk("drop_r9", 4'd9, 32'h0);
        tick();

        // clr in T2 aborts and wipes everything
        host_write(4'd2, 32'd5);
        host_write(4'd3, 32'd7);
        drive_start(OP_ADD, 4'd1, 4'd2, 4'd3);
        tick();
        start = 1'b0;
        tick();
        clr = 1'b1;
        #1;
        chk1("clr_busy", busy_a, 1'b0);
        chk1("clr_done", done_a, 1'b0);
        chk1("clr_err", err_a, 1'b0);
        chk("clr_bus", bus_a, 32'h0);
        chk("clr_hi", hi_a, 32'h0);
        chk("clr_lo", lo_a, 32'h0);
        rd_chk("clr_r2", 4'd2, 32'h0);
        tick();
        clr = 1'b0;
        tick();
        tick();
        rd_chk("clr_r1", 4'd1, 32'h0);
        host_write(4'd2, 32'd5);
        host_write(4'd3, 32'd7);
        run_op("post_clr", OP_ADD, 4'd1, 4'd2, 4'd3);
        rd_chk("post_clr_r1", 4'd1, 32'd12);

        // Back-to-back: start held through DONE launches the next op
        drive_start(OP_ADD, 4'd12, 4'd2, 4'd3);
        tick();
        drive_start(OP_SUB, 4'd13, 4'd3, 4'd2);
        tick();
        tick();
        tick();
        chk1("b2b_done1", done_a, 1'b1);
        rd_chk("b2b_r12", 4'd12, 32'd12);
        tick();
        start = 1'b0;
        chk1("b2b_busy2", busy_a, 1'b1);
        chk1("b2b_done1_off", done_a, 1'b0);
        tick();
        tick();
        tick();
        chk1("b2b_done2", done_a, 1'b1);
        rd_chk("b2b_r13", 4'd13, 32'd2);
        tick();

        // R0 hardwired to zero only in dut_b
        host_write(4'd0, 32'h55);
        rd_chk2("r0_host", 4'd0, 32'h55, 32'h0);
        run_op("r0_dst", OP_ADD, 4'd0, 4'd2, 4'd3);
        rd_chk2("r0_dst", 4'd0, 32'd12, 32'h0);
        run_op("r0_src", OP_ADD, 4'd14, 4'd0, 4'd3);
        rd_chk2("r0_src", 4'd14, 32'd19, 32'd7);
        chk1("r0_done_b", done_b, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_datapath.md
# seq_datapath

Parametrised single-bus datapath with an integrated micro-sequencer, successor to the hand-strobed 32-bit datapath. The old design needs every Rout/Rin/Yin/Zin strobe driven externally. This block instead takes one register-register instruction (`ra <= rb op rc`) through a start/done handshake and generates those strobes internally. It generalises word width, register count and the R0 convention, and adds signed multiply into HI/LO. It sits between the future control unit and the memory subsystem; MAR/MDR stay outside it.

## Interface
- `W`, 32: data word width (≥ 8).
- `NREGS`, 16: general-purpose register count (power of two, ≥ 4); `AW = $clog2(NREGS)`.
- `R0_ZERO`, 0: 1 = R0 reads as 0 and writes to R0 are discarded.

- `clk`  in  1: single clock, all state rising-edge.
- `clr`  in  1: asynchronous, active-high reset.
- `start`  in  1: instruction request; accepted only when `busy`=0.
- `op`  in  4: operation code, sampled with `start`.
- `ra`, `rb`, `rc`  in  AW each: destination, source A, source B.
- `wr_en`  in  1: host register write.
- `wr_addr`  in  AW: host write address.
- `wr_data`  in  W: host write data.
- `rd_addr`  in  AW: host read address.
- `rd_data`  out  W: combinational `R[rd_addr]` (honours `R0_ZERO`).
- `hi`, `lo`  out  W: HI/LO register contents.
- `bus`  out  W: current shared-bus value.
- `busy`  out  1: sequence in progress.
- `done`  out  1: one-cycle completion pulse.
- `err`  out  1: one-cycle pulse; illegal op (with `done`) or host write rejected.

## Operation
- Ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHL, 5 SHR (logical), 6 SHRA, 7 MUL (signed), 8 NOT (`~rb`), 9 NEG (`-rb`). Codes 10–15 are illegal.
- FSM states: IDLE, T1, T2, T3, T4, DONE.
- IDLE/DONE with `start`=1: latch `op`/`ra`/`rb`/`rc`, go to T1. Otherwise go to (or stay in) IDLE.
- Illegal op: the start edge goes directly to DONE with `err`=1. No register, Y, Z, HI or LO changes.
- T1: bus = R[rb]; Y <= bus.
- T2: bus = R[rc] (NOT/NEG: bus = 0); Z (2W bits) <= ALU(Y, bus).
- T3: bus = Zlo. MUL writes LO <= bus and goes to T4. All other ops write R[ra] <= bus and go to DONE.
- T4 (MUL only): bus = Zhi; HI <= bus.
- DONE: `done`=1 for exactly one cycle.
- Bus in IDLE/DONE: 0.
- Arithmetic is modulo 2^W; Zhi = 0 for non-MUL ops. MUL forms the full 2W-bit signed product.
- Shift amount = low `$clog2(W)` bits of the rc operand; the upper bits are ignored.
- Host write is accepted only when `busy`=0. A host write with `busy`=1 is dropped and pulses `err` next cycle; the sequence is unaffected.
- Host write and `start` on the same edge: the write lands first in effect, so T1 reads the new value.
- `R0_ZERO`=1 applies to host writes, sequence writes, bus reads and `rd_data`.

## Timing
- Reset values: all GPRs, Y, Z, HI, LO = 0; state = IDLE; `busy`=`done`=`err`=0; `bus`=0.
- `clr` mid-sequence aborts immediately to IDLE with all state cleared. No partial write survives.
- `busy` is high in T1–T4 and low in IDLE and DONE.
- Latency, counting the accepting edge as edge 0:
  - non-MUL: R[ra] written at edge 3; `done` high from edge 3 to edge 4.
  - MUL: LO at edge 3, HI at edge 4; `done` high from edge 4 to edge 5.
  - illegal op: `done`+`err` high from edge 0 to edge 1.
- Back-to-back: `start` held high in DONE launches the next instruction, giving 4 cycles per non-MUL op.
- `start` while `busy`=1 is ignored silently.

## Structure
- `datapath_pkg` holds:
  - the `op_t` enum (codes above)
  - the `state_t` enum
  - the `bus_sel_t` enum (GPR, ZLO, ZHI, ZERO)
  - `OP_LAST_LEGAL` = 9
- Sub-module `datapath_alu` is combinational: (W-bit A, W-bit B, op) -> 2W-bit result. It is instantiated once.
- Register file, Y, Z, HI, LO, bus mux and FSM live in the top module.

## Test plan
- R2=5, R3=7; ADD ra=1 rb=2 rc=3 -> R1=12 at edge 3, `done` one cycle, `busy` high for 3 cycles.
- R2=0, R3=1; SUB -> R1=0xFFFFFFFF. R6=0x80000000 with R7=4, then R7=36; SHRA -> 0xF8000000 both times.
- R4=0xFFFFFFFD, R5=6; MUL -> LO=0xFFFFFFEE at edge 3, HI=0xFFFFFFFF at edge 4, GPRs unchanged, `done` at edge 4.
- op=12 -> `done`+`err` next cycle, no state change. `wr_en` during `busy` -> write dropped, `err` pulse. `start` during `busy` -> ignored.
- ADD with `clr` asserted in T2 -> all outputs 0 immediately, R1 stays 0, a subsequent ADD runs normally.
- `R0_ZERO`=1: host write 0x55 to R0 -> `rd_data`(0)=0; ADD ra=0 -> R0 still 0; R0 used as rb -> operand reads 0.
